// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with its own bit timer and centre sampling.
// The optional parity bit is enabled by defining UART_RX_PARITY_EN. Parity is even,
// and a parity mismatch is reported on parity_err. When the macro is undefined,
// the frame is plain 8N1 and parity_err is tied to 0.
// Host handshake: rx_valid is a one-cycle strobe with no back-pressure. rx_data,
// frame_err and parity_err are valid in that cycle and hold until the next strobe.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int CNT_W        = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // The start-bit target lands the sample at the start-bit centre.
    // Every later bit is one full period after the previous sample.
    localparam logic [CNT_W-1:0] HALF_T   = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_T   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_meta_q, rx_s_q, rx_prev_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_pend_q, par_pend_d;
    logic                   parity_err_q, parity_err_d;
`endif

    logic             start_edge;
    logic             timed;
    logic             tick;
    logic [CNT_W-1:0] target;

    assign start_edge = rx_prev_q & ~rx_s_q;
    assign target     = (state_q == S_START) ? HALF_T : FULL_T;
    assign timed      = (state_q != S_IDLE) && (state_q != S_BREAK);
    assign tick       = timed && (cnt_q == target);

    // Next-state logic, bit timer, shift register and output updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_pend_d   = par_pend_q;
        parity_err_d = parity_err_q;
`endif
        if (timed) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // The line was high again at mid-bit, so treat the edge as a glitch.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_pend_d = rx_s_q ^ (^shift_q);
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    rx_data_d   = shift_q;
                    rx_valid_d  = 1'b1;
                    frame_err_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_pend_q;
`endif
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Stay here while the line is held low. Edges are not meaningful in this state.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Synchroniser, edge-detect flop and receiver state. A reset mid-frame aborts the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_in;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_pend_q   <= par_pend_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
